// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scheduler: per-register busy bits (int + fp), one
// non-pipelined divider resource, and the two decoder stall outputs.
module issue_scoreboard #(
  parameter int DIV_UNIT_BIT = 5,
  parameter int NUM_WB       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        inst0_valid_i,
  input  logic        inst0_rs1_valid_i,
  input  logic        inst0_rs2_valid_i,
  input  logic        inst0_rs3_valid_i,
  input  logic [4:0]  inst0_rs1_i,
  input  logic [4:0]  inst0_rs2_i,
  input  logic [4:0]  inst0_rs3_i,
  input  logic [2:0]  inst0_rs_fp_i,
  input  logic [1:0]  inst0_rd_type_i,
  input  logic [4:0]  inst0_rd_i,
  input  logic [5:0]  inst0_exe_unit_i,
  input  logic        inst1_valid_i,
  input  logic        inst1_rs1_valid_i,
  input  logic        inst1_rs2_valid_i,
  input  logic        inst1_rs3_valid_i,
  input  logic [4:0]  inst1_rs1_i,
  input  logic [4:0]  inst1_rs2_i,
  input  logic [4:0]  inst1_rs3_i,
  input  logic [2:0]  inst1_rs_fp_i,
  input  logic [1:0]  inst1_rd_type_i,
  input  logic [4:0]  inst1_rd_i,
  input  logic [5:0]  inst1_exe_unit_i,
  input  logic        wb0_valid_i,
  input  logic [1:0]  wb0_rd_type_i,
  input  logic [4:0]  wb0_rd_i,
  input  logic        wb1_valid_i,
  input  logic [1:0]  wb1_rd_type_i,
  input  logic [4:0]  wb1_rd_i,
  input  logic        div_done_i,
  output logic        stall_decoder_inst0_o,
  output logic        stall_decoder_inst1_o,
  output logic [31:0] busy_int_o,
  output logic [31:0] busy_fp_o,
  output logic        div_busy_o
);

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

  logic [31:0] busy_int_q, busy_int_d;
  logic [31:0] busy_fp_q, busy_fp_d;
  div_state_e  div_state_q, div_state_d;

  logic [31:0] set_int, set_fp, clr_int, clr_fp;
  logic        div_busy;
  logic        hazard0, hazard1, pair_conflict;
  logic        inst0_wr, inst0_wr_fp;
  logic        issue0, issue1;
  logic        wb_err;

  // Source hit on a busy bit; int x0 is hardwired and never busy.
  function automatic logic src_hit(input logic v, input logic fp, input logic [4:0] idx,
                                   input logic [31:0] bi, input logic [31:0] bf);
    return v & (fp ? bf[idx] : ((idx != 5'd0) & bi[idx]));
  endfunction

  function automatic logic rd_hit(input logic [1:0] t, input logic [4:0] rd,
                                  input logic [31:0] bi, input logic [31:0] bf);
    return ((t == 2'd1) & (rd != 5'd0) & bi[rd]) | ((t == 2'd2) & bf[rd]);
  endfunction

  function automatic logic match_rd0(input logic v, input logic fp, input logic [4:0] idx,
                                     input logic w, input logic wfp, input logic [4:0] wrd);
    return v & w & (fp == wfp) & (idx == wrd);
  endfunction

  function automatic logic wb_bad(input logic v, input logic [1:0] t, input logic [4:0] rd,
                                  input logic [31:0] bi, input logic [31:0] bf,
                                  input logic [31:0] si, input logic [31:0] sf);
    return v & (((t == 2'd1) & (rd != 5'd0) & !bi[rd] & !si[rd]) |
                ((t == 2'd2) & !bf[rd] & !sf[rd]));
  endfunction

  assign div_busy = (div_state_q == DIV_BUSY);

  always_comb begin
    inst0_wr    = inst0_valid_i & (((inst0_rd_type_i == 2'd1) & (inst0_rd_i != 5'd0)) |
                                   (inst0_rd_type_i == 2'd2));
    inst0_wr_fp = (inst0_rd_type_i == 2'd2);

    hazard0 = inst0_valid_i & (
      src_hit(inst0_rs1_valid_i, inst0_rs_fp_i[0], inst0_rs1_i, busy_int_q, busy_fp_q) |
      src_hit(inst0_rs2_valid_i, inst0_rs_fp_i[1], inst0_rs2_i, busy_int_q, busy_fp_q) |
      src_hit(inst0_rs3_valid_i, inst0_rs_fp_i[2], inst0_rs3_i, busy_int_q, busy_fp_q) |
      rd_hit(inst0_rd_type_i, inst0_rd_i, busy_int_q, busy_fp_q) |
      (inst0_exe_unit_i[DIV_UNIT_BIT] & div_busy));

    hazard1 = inst1_valid_i & (
      src_hit(inst1_rs1_valid_i, inst1_rs_fp_i[0], inst1_rs1_i, busy_int_q, busy_fp_q) |
      src_hit(inst1_rs2_valid_i, inst1_rs_fp_i[1], inst1_rs2_i, busy_int_q, busy_fp_q) |
      src_hit(inst1_rs3_valid_i, inst1_rs_fp_i[2], inst1_rs3_i, busy_int_q, busy_fp_q) |
      rd_hit(inst1_rd_type_i, inst1_rd_i, busy_int_q, busy_fp_q) |
      (inst1_exe_unit_i[DIV_UNIT_BIT] & div_busy));

    // Intra-pair hazards against the older slot's destination.
    pair_conflict =
      match_rd0(inst1_rs1_valid_i, inst1_rs_fp_i[0], inst1_rs1_i, inst0_wr, inst0_wr_fp, inst0_rd_i) |
      match_rd0(inst1_rs2_valid_i, inst1_rs_fp_i[1], inst1_rs2_i, inst0_wr, inst0_wr_fp, inst0_rd_i) |
      match_rd0(inst1_rs3_valid_i, inst1_rs_fp_i[2], inst1_rs3_i, inst0_wr, inst0_wr_fp, inst0_rd_i) |
      match_rd0((inst1_rd_type_i == 2'd1) | (inst1_rd_type_i == 2'd2), inst1_rd_type_i == 2'd2,
                inst1_rd_i, inst0_wr, inst0_wr_fp, inst0_rd_i) |
      (inst0_valid_i & inst0_exe_unit_i[DIV_UNIT_BIT] & inst1_exe_unit_i[DIV_UNIT_BIT]);

    stall_decoder_inst0_o = hazard0;
    stall_decoder_inst1_o = inst1_valid_i & (hazard0 | hazard1 | pair_conflict);

    issue0 = inst0_valid_i & !stall_decoder_inst0_o & !flush_i;
    issue1 = inst1_valid_i & !stall_decoder_inst1_o & !flush_i;
  end

  always_comb begin
    set_int = '0;
    set_fp  = '0;
    clr_int = '0;
    clr_fp  = '0;
    if (issue0 && inst0_rd_type_i == 2'd1) set_int[inst0_rd_i] = 1'b1;
    if (issue0 && inst0_rd_type_i == 2'd2) set_fp[inst0_rd_i]  = 1'b1;
    if (issue1 && inst1_rd_type_i == 2'd1) set_int[inst1_rd_i] = 1'b1;
    if (issue1 && inst1_rd_type_i == 2'd2) set_fp[inst1_rd_i]  = 1'b1;
    if (wb0_valid_i && wb0_rd_type_i == 2'd1) clr_int[wb0_rd_i] = 1'b1;
    if (wb0_valid_i && wb0_rd_type_i == 2'd2) clr_fp[wb0_rd_i]  = 1'b1;
    if (wb1_valid_i && wb1_rd_type_i == 2'd1) clr_int[wb1_rd_i] = 1'b1;
    if (wb1_valid_i && wb1_rd_type_i == 2'd2) clr_fp[wb1_rd_i]  = 1'b1;

    // Set after clear: a same-cycle new writer is younger than the retiring one.
    if (flush_i) begin
      busy_int_d = '0;
      busy_fp_d  = '0;
    end else begin
      busy_int_d = (busy_int_q & ~clr_int) | set_int;
      busy_fp_d  = (busy_fp_q & ~clr_fp) | set_fp;
    end
    busy_int_d[0] = 1'b0;

    div_state_d = div_state_q;
    if (flush_i) begin
      div_state_d = DIV_IDLE;
    end else begin
      case (div_state_q)
        DIV_IDLE: if ((issue0 && inst0_exe_unit_i[DIV_UNIT_BIT]) ||
                      (issue1 && inst1_exe_unit_i[DIV_UNIT_BIT])) div_state_d = DIV_BUSY;
        DIV_BUSY: if (div_done_i) div_state_d = DIV_IDLE;
        default:  div_state_d = DIV_IDLE;
      endcase
    end

    // A writeback to an idle register is only tolerated when the bit is re-set this cycle.
    wb_err = !flush_i & (
      wb_bad(wb0_valid_i, wb0_rd_type_i, wb0_rd_i, busy_int_q, busy_fp_q, set_int, set_fp) |
      wb_bad(wb1_valid_i, wb1_rd_type_i, wb1_rd_i, busy_int_q, busy_fp_q, set_int, set_fp));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_int_q  <= '0;
      busy_fp_q   <= '0;
      div_state_q <= DIV_IDLE;
    end else begin
      busy_int_q  <= busy_int_d;
      busy_fp_q   <= busy_fp_d;
      div_state_q <= div_state_d;
      assert (!wb_err && NUM_WB == 2) else $error("writeback cleared a register that was not busy");
    end
  end

  assign busy_int_o = busy_int_q;
  assign busy_fp_o  = busy_fp_q;
  assign div_busy_o = div_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i;
  logic [4:0]  inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_i;
  logic [2:0]  inst0_rs_fp_i;
  logic [1:0]  inst0_rd_type_i;
  logic [5:0]  inst0_exe_unit_i;
  logic        inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i;
  logic [4:0]  inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_i;
  logic [2:0]  inst1_rs_fp_i;
  logic [1:0]  inst1_rd_type_i;
  logic [5:0]  inst1_exe_unit_i;
  logic        wb0_valid_i, wb1_valid_i;
  logic [1:0]  wb0_rd_type_i, wb1_rd_type_i;
  logic [4:0]  wb0_rd_i, wb1_rd_i;
  logic        div_done_i;
  logic        stall_decoder_inst0_o, stall_decoder_inst1_o;
  logic [31:0] busy_int_o, busy_fp_o;
  logic        div_busy_o;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          compared = 0;
  int          mismatched = 0;

  localparam logic [5:0] ALU = 6'b000001;
  localparam logic [5:0] DIV = 6'b100000;

  issue_scoreboard #(.DIV_UNIT_BIT(5), .NUM_WB(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst0_valid_i(inst0_valid_i), .inst0_rs1_valid_i(inst0_rs1_valid_i),
    .inst0_rs2_valid_i(inst0_rs2_valid_i), .inst0_rs3_valid_i(inst0_rs3_valid_i),
    .inst0_rs1_i(inst0_rs1_i), .inst0_rs2_i(inst0_rs2_i), .inst0_rs3_i(inst0_rs3_i),
    .inst0_rs_fp_i(inst0_rs_fp_i), .inst0_rd_type_i(inst0_rd_type_i), .inst0_rd_i(inst0_rd_i),
    .inst0_exe_unit_i(inst0_exe_unit_i),
    .inst1_valid_i(inst1_valid_i), .inst1_rs1_valid_i(inst1_rs1_valid_i),
    .inst1_rs2_valid_i(inst1_rs2_valid_i), .inst1_rs3_valid_i(inst1_rs3_valid_i),
    .inst1_rs1_i(inst1_rs1_i), .inst1_rs2_i(inst1_rs2_i), .inst1_rs3_i(inst1_rs3_i),
    .inst1_rs_fp_i(inst1_rs_fp_i), .inst1_rd_type_i(inst1_rd_type_i), .inst1_rd_i(inst1_rd_i),
    .inst1_exe_unit_i(inst1_exe_unit_i),
    .wb0_valid_i(wb0_valid_i), .wb0_rd_type_i(wb0_rd_type_i), .wb0_rd_i(wb0_rd_i),
    .wb1_valid_i(wb1_valid_i), .wb1_rd_type_i(wb1_rd_type_i), .wb1_rd_i(wb1_rd_i),
    .div_done_i(div_done_i),
    .stall_decoder_inst0_o(stall_decoder_inst0_o), .stall_decoder_inst1_o(stall_decoder_inst1_o),
    .busy_int_o(busy_int_o), .busy_fp_o(busy_fp_o), .div_busy_o(div_busy_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_inputs();
    flush_i = 0; div_done_i = 0;
    inst0_valid_i = 0; inst0_rs1_valid_i = 0; inst0_rs2_valid_i = 0; inst0_rs3_valid_i = 0;
    inst0_rs1_i = 0; inst0_rs2_i = 0; inst0_rs3_i = 0; inst0_rs_fp_i = 0;
    inst0_rd_type_i = 0; inst0_rd_i = 0; inst0_exe_unit_i = ALU;
    inst1_valid_i = 0; inst1_rs1_valid_i = 0; inst1_rs2_valid_i = 0; inst1_rs3_valid_i = 0;
    inst1_rs1_i = 0; inst1_rs2_i = 0; inst1_rs3_i = 0; inst1_rs_fp_i = 0;
    inst1_rd_type_i = 0; inst1_rd_i = 0; inst1_exe_unit_i = ALU;
    wb0_valid_i = 0; wb0_rd_type_i = 0; wb0_rd_i = 0;
    wb1_valid_i = 0; wb1_rd_type_i = 0; wb1_rd_i = 0;
  endtask

  // Sources given as {valid, fp, index}; rs1/rs2/rs3 in argument order.
  task automatic drive_inst0(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                             input logic [1:0] rd_type, input logic [4:0] rd, input logic [5:0] exe);
    inst0_valid_i = 1;
    inst0_rs1_valid_i = s1[6]; inst0_rs2_valid_i = s2[6]; inst0_rs3_valid_i = s3[6];
    inst0_rs_fp_i = {s3[5], s2[5], s1[5]};
    inst0_rs1_i = s1[4:0]; inst0_rs2_i = s2[4:0]; inst0_rs3_i = s3[4:0];
    inst0_rd_type_i = rd_type; inst0_rd_i = rd; inst0_exe_unit_i = exe;
  endtask

  task automatic drive_inst1(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                             input logic [1:0] rd_type, input logic [4:0] rd, input logic [5:0] exe);
    inst1_valid_i = 1;
    inst1_rs1_valid_i = s1[6]; inst1_rs2_valid_i = s2[6]; inst1_rs3_valid_i = s3[6];
    inst1_rs_fp_i = {s3[5], s2[5], s1[5]};
    inst1_rs1_i = s1[4:0]; inst1_rs2_i = s2[4:0]; inst1_rs3_i = s3[4:0];
    inst1_rd_type_i = rd_type; inst1_rd_i = rd; inst1_exe_unit_i = exe;
  endtask

  task automatic drive_wb(input int port, input logic [1:0] t, input logic [4:0] rd);
    if (port == 0) begin wb0_valid_i = 1; wb0_rd_type_i = t; wb0_rd_i = rd; end
    else           begin wb1_valid_i = 1; wb1_rd_type_i = t; wb1_rd_i = rd; end
  endtask

  // Scoreboard
  task automatic want(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        mismatched++;
        $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [6:0] src(input logic fp, input logic [4:0] idx);
    return {1'b1, fp, idx};
  endfunction

  localparam logic [6:0] NONE = 7'd0;

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    want("rst_busy_int", 0); want("rst_busy_fp", 0); want("rst_div", 0);
    want("rst_stall0", 0); want("rst_stall1", 0);
    got(busy_int_o); got(busy_fp_o); got({31'd0, div_busy_o});
    got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});

    // add x5 <- x1, x2 with slot 1 idle
    drive_inst0(src(0, 1), src(0, 2), NONE, 2'd1, 5'd5, ALU);
    want("add_stall0", 0); want("add_stall1", 0);
    #1; got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    tick(); clear_inputs();
    want("add_busy_int", 32'h20);
    got(busy_int_o);

    // RAW on busy x5; writeback in the same cycle does not bypass
    drive_inst0(src(0, 5), NONE, NONE, 2'd0, 5'd0, ALU);
    drive_inst1(NONE, NONE, NONE, 2'd0, 5'd0, ALU);
    drive_wb(0, 2'd1, 5'd5);
    want("raw_stall0_T", 1); want("raw_stall1_T", 1);
    #1; got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    tick(); wb0_valid_i = 0;
    want("raw_busy_int_T1", 0); want("raw_stall0_T1", 0); want("raw_stall1_T1", 0);
    #1; got(busy_int_o); got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    tick(); clear_inputs();

    // Pair RAW through rs3 on f3, then slot 1 alone still blocked by busy f3
    drive_inst0(NONE, NONE, NONE, 2'd2, 5'd3, ALU);
    drive_inst1(NONE, NONE, src(1, 3), 2'd0, 5'd0, ALU);
    want("pair_stall0", 0); want("pair_stall1", 1);
    #1; got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    tick(); inst0_valid_i = 0;
    want("pair_busy_fp", 32'h8); want("alone_stall0", 0); want("alone_stall1", 1);
    #1; got(busy_fp_o); got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    drive_wb(1, 2'd2, 5'd3);
    tick(); clear_inputs();
    want("wb_fp_clear", 0);
    got(busy_fp_o);

    // Int x0: never marked busy, never matched by the younger slot
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd0, ALU);
    drive_inst1(src(0, 0), NONE, NONE, 2'd1, 5'd0, ALU);
    want("x0_stall1", 0);
    #1; got({31'd0, stall_decoder_inst1_o});
    tick(); clear_inputs();
    want("x0_busy_int", 0);
    got(busy_int_o);

    // Divider structural hazard
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd10, DIV);
    tick(); clear_inputs();
    want("div_busy_set", 1); want("div_busy_int", 32'h400);
    got({31'd0, div_busy_o}); got(busy_int_o);
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd11, DIV);
    drive_wb(0, 2'd1, 5'd10);
    want("div2_stall0_a", 1);
    #1; got({31'd0, stall_decoder_inst0_o});
    tick(); wb0_valid_i = 0;
    div_done_i = 1;
    want("div2_stall0_done", 1); want("div_busy_done_cyc", 1);
    #1; got({31'd0, stall_decoder_inst0_o}); got({31'd0, div_busy_o});
    tick(); div_done_i = 0;
    want("div_idle", 0); want("div2_stall0_free", 0);
    #1; got({31'd0, div_busy_o}); got({31'd0, stall_decoder_inst0_o});
    tick(); clear_inputs();
    want("div2_issued", 1); want("div2_busy_int", 32'h800);
    got({31'd0, div_busy_o}); got(busy_int_o);
    drive_wb(0, 2'd1, 5'd11);
    div_done_i = 1;
    tick(); clear_inputs();
    want("div2_retired", 0); want("div2_busy_clear", 0);
    got({31'd0, div_busy_o}); got(busy_int_o);

    // Both slots on the divider
    drive_inst0(NONE, NONE, NONE, 2'd0, 5'd0, DIV);
    drive_inst1(NONE, NONE, NONE, 2'd0, 5'd0, DIV);
    want("dual_div_stall0", 0); want("dual_div_stall1", 1);
    #1; got({31'd0, stall_decoder_inst0_o}); got({31'd0, stall_decoder_inst1_o});
    clear_inputs();

    // Pair WAW on the same int destination
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd9, ALU);
    drive_inst1(NONE, NONE, NONE, 2'd1, 5'd9, ALU);
    want("pair_waw_stall1", 1);
    #1; got({31'd0, stall_decoder_inst1_o});
    clear_inputs();

    // Issue set wins over a same-cycle writeback clear
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd7, ALU);
    drive_wb(1, 2'd1, 5'd7);
    tick(); clear_inputs();
    want("set_wins", 32'h80);
    got(busy_int_o);
    drive_wb(0, 2'd1, 5'd7);
    tick(); clear_inputs();
    want("x7_clear", 0);
    got(busy_int_o);

    // Flush clears every busy bit and the divider
    drive_inst0(NONE, NONE, NONE, 2'd1, 5'd1, DIV);
    drive_inst1(NONE, NONE, NONE, 2'd2, 5'd2, ALU);
    tick(); clear_inputs();
    want("pre_flush_int", 32'h2); want("pre_flush_fp", 32'h4); want("pre_flush_div", 1);
    got(busy_int_o); got(busy_fp_o); got({31'd0, div_busy_o});
    drive_inst0(src(0, 1), NONE, NONE, 2'd0, 5'd0, ALU);
    drive_inst1(NONE, NONE, NONE, 2'd1, 5'd3, ALU);
    want("pre_flush_stall0", 1);
    #1; got({31'd0, stall_decoder_inst0_o});
    flush_i = 1;
    tick(); flush_i = 0; inst1_valid_i = 0;
    want("flush_int", 0); want("flush_fp", 0); want("flush_div", 0); want("flush_read_x1", 0);
    #1; got(busy_int_o); got(busy_fp_o); got({31'd0, div_busy_o});
    got({31'd0, stall_decoder_inst0_o});
    tick(); clear_inputs();

    // Every queued expectation should have been consumed
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL leftover_expectations: observed %0d required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-issue hazard scheduler sitting beside the decoder stage; generates the two decoder stall signals every cycle.
- Keeps a busy bit per architectural destination (32 int + 32 fp) and clears it on writeback.
- Tracks one non-pipelined execution unit (divider) as a structural resource.
- Enforces in-order pair issue: inst1 never issues without inst0.

Parameters:
DIV_UNIT_BIT, 5, index of exe_unit bit that selects the non-pipelined divider
NUM_WB, 2, writeback ports (fixed at 2; parameter exists for documentation only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush from writeback
instN_valid_i  in  1  decoder slot N valid, pre-stall (N=0,1)
instN_rs1_valid_i / rs2_valid_i / rs3_valid_i  in  1 each  source used
instN_rs1_i / rs2_i / rs3_i  in  5 each  source register index
instN_rs_fp_i  in  3  per-source file select, bit0=rs1, bit1=rs2, bit2=rs3; 1=fp
instN_rd_type_i  in  2  0=none, 1=int, 2=fp, 3=treated as none
instN_rd_i  in  5  destination index
instN_exe_unit_i  in  6  one-hot execution unit
wbM_valid_i  in  1  writeback M valid (M=0,1)
wbM_rd_type_i  in  2  writeback file, same encoding as rd_type
wbM_rd_i  in  5  writeback register
div_done_i  in  1  divider result accepted, one-cycle pulse
stall_decoder_inst0_o  out  1  hold slot 0 (and slot 1)
stall_decoder_inst1_o  out  1  hold slot 1
busy_int_o  out  32  int busy vector, debug
busy_fp_o  out  32  fp busy vector, debug
div_busy_o  out  1  divider occupied

Behaviour:
- Reset: busy_int/busy_fp = 0, divider FSM = IDLE, stall outputs = 0 (combinational from zeroed state; both valids low).
- Stalls are combinational from registered state plus current decoder inputs; zero-cycle latency. Writeback in the same cycle does NOT unblock (no bypass); the bit is cleared at the edge and the instruction issues the next cycle.
- Int x0 is never marked busy, and sources reading int x0 never stall. fp f0 is an ordinary register.
- hazard0 = inst0_valid & ( any valid source whose busy bit in the selected file is set | rd busy (WAW) | (exe_unit[DIV_UNIT_BIT] & div_busy) ).
- stall_decoder_inst0_o = hazard0.
- stall_decoder_inst1_o = inst1_valid & ( hazard0 | hazard1 | any inst1 valid source matching inst0's rd in the same file (RAW) | inst1 rd == inst0 rd in same file (WAW) | both slots select the divider ).
  - hazard1 is the same check as hazard0, applied to inst1.
  - The inst0-rd comparisons apply only if inst0 is valid with rd_type 1/2, and not when inst0 rd is int x0.
- Issue: slot N issues when valid & !stall_N & !flush_i.
  - On issue with rd_type 1/2 (and not int x0), set busy[rd] at the next edge.
- Writeback: each valid wb port clears its busy bit at the edge.
  - If set and clear hit the same bit in the same cycle, set wins (the new writer is younger).
  - Both wb ports clearing the same bit is legal.
- Divider FSM: IDLE -> BUSY when a divider instruction issues. BUSY -> IDLE on div_done_i. div_done_i in IDLE is ignored.
  - An issue and div_done_i in the same cycle are impossible, because a div cannot issue while BUSY.
- Flush: at the edge, all busy bits clear and FSM -> IDLE.
  - Rationale: in-order writeback means everything older is already retired, and everything younger is killed.
  - Issues and writebacks in a flush cycle are discarded.
  - Stall outputs during flush are don't-care; the decoder masks valid with flush.
- rst overrides flush, issue and writeback.
- Invariant to assert: wb clearing a bit that is not set is an error in simulation (except int x0).

Test Plan:
- Reset, then inst0 add x5 with inst1 idle -> no stall; next cycle busy_int_o=0x20. wb0 x5 -> busy_int_o=0 one edge later.
- x5 busy; inst0 reads x5 -> both stalls=1. wb0 x5 in cycle T -> stalls still 1 in T, 0 in T+1.
- Pair: inst0 writes f3, inst1 reads f3 as rs3 -> stall0=0, stall1=1. Next cycle inst1 alone is still stalled because busy_fp_o[3]=1.
- inst0 is a div (exe_unit bit5) -> div_busy_o=1. Next div stalls until div_done_i; it issues the cycle after that pulse.
- Same-cycle conflict: issue writes x7 while wb1 clears x7 -> busy_int_o[7]=1.
- Busy x1,f2 plus div BUSY, then flush_i=1 -> next cycle busy vectors=0, div_busy_o=0, and a pending read of x1 issues.
